// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue, held in a pending register, and committed when the busy window ends.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] opa_E,
  input  logic [31:0] opb_E,
  output logic        busy,
  output logic        md_active,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;
  logic          commit_q, commit_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic        is_md;
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] dvd, dvs, q_raw, r_raw, quot, rem;

  assign is_md = start && (mdop >= 3'd1) && (mdop <= 3'd4);

  // Low 64 bits of a sign-extended product equal the signed 32x32 product.
  assign a_sx   = {{32{opa_E[31]}}, opa_E};
  assign b_sx   = {{32{opb_E[31]}}, opb_E};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'b0, opa_E} * {32'b0, opb_E};

  // One unsigned divider on magnitudes; signs are reapplied afterwards.
  // A zero divisor is replaced by 1 so the divider never sees it; such results are never committed.
  assign div_signed = (mdop == 3'd3);
  assign a_neg      = div_signed && opa_E[31];
  assign b_neg      = div_signed && opb_E[31];
  assign dvd        = a_neg ? -opa_E : opa_E;
  assign dvs        = (opb_E == '0) ? 32'd1 : (b_neg ? -opb_E : opb_E);
  assign q_raw      = dvd / dvs;
  assign r_raw      = dvd % dvs;
  assign quot       = (a_neg ^ b_neg) ? -q_raw : q_raw;
  assign rem        = a_neg ? -r_raw : r_raw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mdop)
            3'd1, 3'd2: begin
              pend_d   = (mdop == 3'd1) ? prod_s : prod_u;
              commit_d = 1'b1;
              cnt_d    = CW'(MULT_CYCLES);
              state_d  = S_BUSY;
            end
            3'd3, 3'd4: begin
              pend_d   = {rem, quot};
              commit_d = (opb_E != '0);
              cnt_d    = CW'(DIV_CYCLES);
              state_d  = S_BUSY;
            end
            3'd5:    hi_d = opa_E;
            3'd6:    lo_d = opa_E;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (commit_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pend_q   <= '0;
      commit_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign md_active = busy | is_md;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table for arithmetic results plus hand sequences for timing corners.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] opa_E, opb_E;
  logic        busy, md_active;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .opa_E(opa_E), .opb_E(opb_E), .busy(busy), .md_active(md_active),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          n;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Counts negedges with busy high, checking HI/LO hold the old model values; bounded.
  task automatic count_busy(output int n, output bit held);
    n = 0;
    held = 1'b1;
    while (busy === 1'b1 && n < 200) begin
      if (hi_out !== exp_hi || lo_out !== exp_lo) held = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; mdop = op; opa_E = a; opb_E = b;
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; mdop = 3'd0; opa_E = '0; opb_E = '0;
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] v);
    issue(op, v, 32'h0);
    @(negedge clk);
    idle_inputs();
    if (op == 3'd5) exp_hi = v; else exp_lo = v;
  endtask

  initial begin
    int n;
    bit held;

    vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
    vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[6] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[7] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8] = '{3'd4, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 10};
    vecs[9] = '{3'd3, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 10};

    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_md_active", {31'b0, md_active}, 32'h0);
    chk("reset_hi", hi_out, 32'h0);
    chk("reset_lo", lo_out, 32'h0);
    reset = 1'b1;

    // No-op codes leave everything alone and never raise md_active.
    issue(3'd7, 32'hDEAD, 32'hBEEF);
    chk("noop7_md_active", {31'b0, md_active}, 32'h0);
    @(negedge clk);
    mdop = 3'd0;
    #1 chk("noop0_md_active", {31'b0, md_active}, 32'h0);
    @(negedge clk);
    idle_inputs();
    chk("noop_busy", {31'b0, busy}, 32'h0);
    chk("noop_hi", hi_out, 32'h0);
    chk("noop_lo", lo_out, 32'h0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_md_active", i), {31'b0, md_active}, 32'h1);
      @(negedge clk);
      idle_inputs();
      count_busy(n, held);
      chk($sformatf("v%0d_busy_cycles", i), n, vecs[i].n);
      chk($sformatf("v%0d_hold", i), {31'b0, held}, 32'h1);
      exp_hi = vecs[i].hi;
      exp_lo = vecs[i].lo;
      chk($sformatf("v%0d_hi", i), hi_out, exp_hi);
      chk($sformatf("v%0d_lo", i), lo_out, exp_lo);
    end

    // Divide by zero keeps HI/LO; a mid-busy mtlo is ignored.
    move_to(3'd5, 32'h11);
    chk("mthi_hi", hi_out, 32'h11);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    move_to(3'd6, 32'h22);
    chk("mtlo_lo", lo_out, 32'h22);
    chk("mtlo_hi_kept", hi_out, 32'h11);
    issue(3'd3, 32'h5, 32'h0);
    @(negedge clk);
    idle_inputs();
    n = 0;
    held = 1'b1;
    while (busy === 1'b1 && n < 200) begin
      if (hi_out !== exp_hi || lo_out !== exp_lo) held = 1'b0;
      n++;
      if (n == 3) begin
        start = 1'b1; mdop = 3'd6; opa_E = 32'h99;
      end else idle_inputs();
      @(negedge clk);
    end
    idle_inputs();
    chk("div0_busy_cycles", n, 10);
    chk("div0_hold", {31'b0, held}, 32'h1);
    chk("div0_hi", hi_out, 32'h11);
    chk("div0_lo", lo_out, 32'h22);

    // Reset in the third busy cycle aborts the multiply for good.
    issue(3'd1, 32'h3, 32'h4);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_busy", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_lo", lo_out, 32'h0);
    repeat (10) @(negedge clk);
    chk("rst_after_busy", {31'b0, busy}, 32'h0);
    chk("rst_after_hi", hi_out, 32'h0);
    chk("rst_after_lo", lo_out, 32'h0);

    // mthi then mult on the very next cycle, then multu in the cycle busy falls.
    issue(3'd5, 32'h5, 32'h0);
    @(negedge clk);
    exp_hi = 32'h5;
    chk("b2b_mthi_hi", hi_out, 32'h5);
    start = 1'b1; mdop = 3'd1; opa_E = 32'h2; opb_E = 32'h3;
    #1 chk("b2b_mult_md_active", {31'b0, md_active}, 32'h1);
    @(negedge clk);
    idle_inputs();
    count_busy(n, held);
    chk("b2b_mult_cycles", n, 5);
    chk("b2b_mult_hold", {31'b0, held}, 32'h1);
    exp_hi = 32'h0;
    exp_lo = 32'h6;
    chk("b2b_mult_hi", hi_out, 32'h0);
    chk("b2b_mult_lo", lo_out, 32'h6);
    start = 1'b1; mdop = 3'd2; opa_E = 32'h10; opb_E = 32'h10;
    @(negedge clk);
    idle_inputs();
    count_busy(n, held);
    chk("b2b_multu_cycles", n, 5);
    chk("b2b_multu_hold", {31'b0, held}, 32'h1);
    chk("b2b_multu_hi", hi_out, 32'h0);
    chk("b2b_multu_lo", lo_out, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
